// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: opcodes, unit count and FSM state encoding.
package alu_pkg;

  localparam int NUM_FU = 8;

  localparam logic [2:0] OP_SUMA        = 3'd0;
  localparam logic [2:0] OP_COMPLEMENTO = 3'd1;
  localparam logic [2:0] OP_SHIFTL      = 3'd2;
  localparam logic [2:0] OP_SHIFTR      = 3'd3;
  localparam logic [2:0] OP_COMPC       = 3'd4;
  localparam logic [2:0] OP_COMPN       = 3'd5;
  localparam logic [2:0] OP_RSVD        = 3'd6;
  localparam logic [2:0] OP_LOAD        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_timeout_counter.sv
// WAIT-state watchdog: counts enabled cycles from zero and flags the last allowed one.
module alu_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// One-command-at-a-time controller that starts an ALU unit, waits for its done
// (with timeout) and returns the captured result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a command; operands latched on acceptance
// ST_ISSUE | one-cycle start pulse and rd strobe to the selected unit
// ST_WAIT  | waiting for the selected unit's done, watchdog running
// ST_WRITE | result strobe with wr, captured data presented
// ST_ERR   | error strobe (reserved opcode or timeout), data forced to 0
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_opcode,
  input  logic [DATA_W-1:0]        cmd_a,
  input  logic [DATA_W-1:0]        cmd_b,
  output logic [NUM_FU-1:0]        fu_start,
  output logic [DATA_W-1:0]        fu_a,
  output logic [DATA_W-1:0]        fu_b,
  input  logic [NUM_FU-1:0]        fu_done,
  input  logic [NUM_FU*DATA_W-1:0] fu_result,
  output logic                     rd,
  output logic                     wr,
  output logic                     res_valid,
  output logic [DATA_W-1:0]        res_data,
  output logic                     res_err,
  output logic                     busy
);

  seq_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic              sel_done;
  logic [DATA_W-1:0] sel_result;
  logic              expired;

  // Only the unit named by the latched opcode is ever listened to.
  assign sel_done   = fu_done[op_q];
  assign sel_result = fu_result[int'(op_q)*DATA_W +: DATA_W];

  alu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ST_WAIT),
    .enable  (state_q == ST_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = (cmd_opcode == OP_RSVD) ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = sel_done ? ST_WRITE : ST_WAIT;
      ST_WAIT: begin
        if (sel_done) begin
          state_d = ST_WRITE;
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      fu_a     <= '0;
      fu_b     <= '0;
      res_data <= '0;
    end else begin
      if (state_q == ST_IDLE && cmd_valid) begin
        op_q <= cmd_opcode;
        fu_a <= cmd_a;
        fu_b <= cmd_b;
      end
      if (state_d == ST_ERR) begin
        res_data <= '0;
      end else if ((state_q == ST_ISSUE || state_q == ST_WAIT) && sel_done) begin
        res_data <= sel_result;
      end
    end
  end

  // Strobes are masked while rst is high so an aborted operation emits nothing.
  always_comb begin
    cmd_ready = 1'b0;
    fu_start  = '0;
    rd        = 1'b0;
    wr        = 1'b0;
    res_valid = 1'b0;
    res_err   = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE:  cmd_ready = 1'b1;
        ST_ISSUE: begin
          fu_start[op_q]    = 1'b1;
          fu_start[OP_RSVD] = 1'b0;
          rd                = 1'b1;
        end
        ST_WRITE: begin
          res_valid = 1'b1;
          wr        = 1'b1;
        end
        ST_ERR: begin
          res_valid = 1'b1;
          res_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
